// File: rtl/bram_axi_master_if.sv
// AXI4 master-side bus bundle between the BRAM-style initiator and the crossbar.
interface bram_axi_master_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/bram_axi_master.sv
// BRAM-style single-word client port bridged to single-beat AXI4 master transactions.
// One transaction outstanding at a time; completion is a one-cycle rvalid_o pulse.
module bram_axi_master #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID         = 0
) (
    input  logic                        clk_i,
    input  logic                        rst,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [AXI_DATA_WIDTH/8-1:0] we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic                        busy_o,
    bram_axi_master_if.master           m
);
    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE   = $clog2(STRB_W);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [STRB_W-1:0]         r_we;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic                      r_rvalid;
    logic                      r_err;
    logic                      r_aw_done;
    logic                      r_w_done;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_unused;

    assign w_aw_hs   = m.awvalid & m.awready;
    assign w_w_hs    = m.wvalid & m.wready;
    assign w_aw_done = r_aw_done | w_aw_hs;
    assign w_w_done  = r_w_done | w_w_hs;

    // IDs, low response bit and rlast carry no information for a single outstanding beat
    assign w_unused = ^{m.bid, m.bresp[0], m.rid, m.rresp[0], m.rlast};

    // Fixed single-beat burst attributes and registered payload
    assign m.awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m.awaddr  = r_addr & ALIGN_MASK;
    assign m.awlen   = 8'd0;
    assign m.awsize  = 3'(SIZE);
    assign m.awburst = 2'b01;
    assign m.wdata   = r_wdata;
    assign m.wstrb   = r_we;
    assign m.wlast   = 1'b1;
    assign m.arid    = AXI_ID_WIDTH'(AXI_ID);
    assign m.araddr  = r_addr & ALIGN_MASK;
    assign m.arlen   = 8'd0;
    assign m.arsize  = 3'(SIZE);
    assign m.arburst = 2'b01;

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (req_i) w_state_nxt = (we_i != '0) ? S_WRITE : S_RD_ADDR;
            S_WRITE:   if (w_aw_done && w_w_done) w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (m.bvalid) w_state_nxt = S_IDLE;
            S_RD_ADDR: if (m.arready) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (m.rvalid) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state; each valid drops once its channel completed
    always_comb begin
        gnt_o     = 1'b0;
        m.awvalid = 1'b0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        m.arvalid = 1'b0;
        m.rready  = 1'b0;
        busy_o    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    gnt_o = req_i;
            S_WRITE: begin
                m.awvalid = ~r_aw_done;
                m.wvalid  = ~r_w_done;
            end
            S_WR_RESP: m.bready  = 1'b1;
            S_RD_ADDR: m.arvalid = 1'b1;
            S_RD_DATA: m.rready  = 1'b1;
            default:   busy_o    = 1'b1;
        endcase
    end

    // Request capture, per-channel write progress and completion reporting
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_addr    <= '0;
            r_we      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_addr    <= addr_i;
                        r_we      <= we_i;
                        r_wdata   <= wdata_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) r_aw_done <= 1'b1;
                    if (w_w_hs)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (m.bvalid) begin
                        r_rvalid <= 1'b1;
                        r_err    <= m.bresp[1];
                    end
                end
                S_RD_DATA: begin
                    if (m.rvalid) begin
                        r_rdata  <= m.rdata;
                        r_rvalid <= 1'b1;
                        r_err    <= m.rresp[1];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_axi_master.sv
// Bench for bram_axi_master: cycle-stepped client and AXI slave with a word-memory reference model.
module tb_bram_axi_master;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 8;
    localparam int unsigned IW = 4;
    localparam int FAST = 0;
    localparam int SKEW = 1;
    localparam int RAND = 2;

    logic          clk;
    logic          rst;
    logic          req_i;
    logic          gnt_o;
    logic [SW-1:0] we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic          busy_o;

    bram_axi_master_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) axi ();

    bram_axi_master #(
        .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID(0)
    ) dut (
        .clk_i(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .busy_o(busy_o), .m(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    resp;
    } req_t;

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] rdata;
        logic          err;
        int            gcyc;
    } exp_t;

    req_t          req_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    logic [DW-1:0] slave_mem [logic [AW-1:0]];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_gnt    = 0;
    int n_cpl    = 0;

    req_t          cur;
    logic [1:0]    cur_resp;
    logic          aw_seen, w_seen, ar_seen, committed;
    logic          aw_pend, w_pend, ar_pend;
    int            aw_hi, b_wait, r_wait;
    logic [AW-1:0] aw_addr_s, ar_addr_s, last_araddr;
    logic [DW-1:0] w_data_s, last_rdata;
    logic [SW-1:0] w_strb_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [AW-1:0] word_of(input logic [AW-1:0] a);
        return AW'((a / 8) * 8);
    endfunction

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] slave_get(input logic [AW-1:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : init_val(a);
    endfunction

    task automatic push_req(input logic [SW-1:0] we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] resp);
        req_t r;
        r.we = we; r.addr = a; r.wdata = d; r.resp = resp;
        req_q.push_back(r);
    endtask

    // One iteration per clock: drive at edge+1, sample at edge+2, then wait for the next edge
    task automatic run(input int mode, input int budget);
        int   n;
        req_t h;
        exp_t e;
        logic [AW-1:0] wa;
        n = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            if (req_q.size() != 0) begin
                h = req_q[0];
                req_i = 1'b1; we_i = h.we; addr_i = h.addr; wdata_i = h.wdata;
            end else begin
                req_i = 1'b0; we_i = '0; addr_i = $urandom; wdata_i = {$urandom, $urandom};
            end
            case (mode)
                FAST: begin axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1; end
                SKEW: begin axi.awready = (aw_hi >= 3); axi.wready = 1'b1; axi.arready = 1'b1; end
                default: begin
                    axi.awready = 1'($urandom_range(0, 1));
                    axi.wready  = 1'($urandom_range(0, 1));
                    axi.arready = 1'($urandom_range(0, 1));
                end
            endcase
            axi.bvalid = 1'b0; axi.bresp = 2'($urandom); axi.bid = 4'($urandom);
            if (aw_seen && w_seen) begin
                if (b_wait == 0) begin axi.bvalid = 1'b1; axi.bresp = cur_resp; end
                else b_wait--;
            end
            axi.rvalid = 1'b0; axi.rdata = {$urandom, $urandom}; axi.rresp = 2'($urandom);
            axi.rlast = 1'($urandom); axi.rid = 4'($urandom);
            if (ar_seen) begin
                if (r_wait == 0) begin
                    axi.rvalid = 1'b1; axi.rdata = slave_get(ar_addr_s);
                    axi.rresp = cur_resp; axi.rlast = 1'b1;
                end else r_wait--;
            end
            #1;
            if (rvalid_o) begin
                check("cpl_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.is_rd) begin
                        check("rdata", rdata_o, e.rdata);
                        last_rdata = e.rdata;
                    end else check("rdata_hold", rdata_o, last_rdata);
                    check("err", 64'(err_o), 64'(e.err));
                    if (mode != RAND) check("latency", 64'(cyc - e.gcyc), (mode == FAST) ? 3 : 6);
                    n_cpl++;
                end
            end
            if (gnt_o) begin
                check("gnt_req", 64'(req_i), 1);
                check("gnt_single_outstanding", 64'(exp_q.size() == 0), 1);
                if (req_q.size() != 0) begin
                    h = req_q.pop_front();
                    wa = word_of(h.addr);
                    e.is_rd = (h.we == '0); e.err = h.resp[1]; e.gcyc = cyc; e.rdata = '0;
                    if (e.is_rd) e.rdata = ref_get(wa);
                    else ref_mem[wa] = merge(ref_get(wa), h.wdata, h.we);
                    exp_q.push_back(e);
                    cur = h; cur_resp = h.resp; n_gnt++;
                    b_wait = (mode == RAND) ? int'($urandom_range(0, 3)) : 0;
                    r_wait = (mode == RAND) ? int'($urandom_range(0, 3)) : 0;
                end
            end
            if (axi.bready) begin
                check("bready_after_aw_w", 64'(aw_seen && w_seen), 1);
                if (axi.bvalid) begin aw_seen = 0; w_seen = 0; aw_hi = 0; committed = 0; end
            end
            if (axi.rready) begin
                check("rready_after_ar", 64'(ar_seen), 1);
                if (axi.rvalid) ar_seen = 0;
            end
            if (aw_pend) check("awvalid_held", 64'(axi.awvalid), 1);
            if (axi.awvalid) begin
                check("aw_once", 64'(aw_seen), 0);
                aw_hi++;
                if (axi.awready) begin
                    check("awaddr", 64'(axi.awaddr), 64'(word_of(cur.addr)));
                    check("awlen", 64'(axi.awlen), 0);
                    check("awsize", 64'(axi.awsize), 3);
                    check("awburst", 64'(axi.awburst), 1);
                    check("awid", 64'(axi.awid), 0);
                    aw_seen = 1; aw_addr_s = axi.awaddr;
                end
            end
            aw_pend = axi.awvalid && !axi.awready;
            if (w_pend) check("wvalid_held", 64'(axi.wvalid), 1);
            if (axi.wvalid) begin
                check("w_once", 64'(w_seen), 0);
                if (axi.wready) begin
                    check("wstrb", 64'(axi.wstrb), 64'(cur.we));
                    check("wdata", axi.wdata, cur.wdata);
                    check("wlast", 64'(axi.wlast), 1);
                    w_seen = 1; w_data_s = axi.wdata; w_strb_s = axi.wstrb;
                end
            end
            w_pend = axi.wvalid && !axi.wready;
            if (aw_seen && w_seen && !committed) begin
                slave_mem[aw_addr_s] = merge(slave_get(aw_addr_s), w_data_s, w_strb_s);
                committed = 1;
            end
            if (ar_pend) check("arvalid_held", 64'(axi.arvalid), 1);
            if (axi.arvalid) begin
                check("ar_once", 64'(ar_seen), 0);
                if (axi.arready) begin
                    check("araddr", 64'(axi.araddr), 64'(word_of(cur.addr)));
                    check("arlen", 64'(axi.arlen), 0);
                    check("arsize", 64'(axi.arsize), 3);
                    check("arburst", 64'(axi.arburst), 1);
                    check("arid", 64'(axi.arid), 0);
                    ar_seen = 1; ar_addr_s = axi.araddr; last_araddr = axi.araddr;
                end
            end
            ar_pend = axi.arvalid && !axi.arready;
            cyc++; n++;
            @(posedge clk); #1;
        end
        check("drained", 64'(req_q.size() + exp_q.size()), 0);
        req_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 0);
        check({tag, "_gnt"}, 64'(gnt_o), 0);
        check({tag, "_rvalid"}, 64'(rvalid_o), 0);
        check({tag, "_err"}, 64'(err_o), 0);
        check({tag, "_rdata"}, rdata_o, 0);
        check({tag, "_valids"}, 64'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
        check({tag, "_readies"}, 64'({axi.bready, axi.rready}), 0);
    endtask

    initial begin
        int g0, c0;
        rst = 1'b1; req_i = 1'b0; we_i = '0; addr_i = '0; wdata_i = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = '0; axi.bid = '0;
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rid = '0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; committed = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_hi = 0; b_wait = 0; r_wait = 0;
        aw_addr_s = '0; ar_addr_s = '0; last_araddr = '0; w_data_s = '0; w_strb_s = '0;
        last_rdata = '0; cur = '{default: '0}; cur_resp = '0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Read with all readies high
        slave_mem[32'h1234_5678] = 64'hDEAD_BEEF_0123_4567;
        ref_mem[32'h1234_5678]   = 64'hDEAD_BEEF_0123_4567;
        push_req(8'h00, 32'h1234_5678, '0, 2'b00);
        run(FAST, 50);
        check("read_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
        check("read_araddr", 64'(last_araddr), 64'h1234_5678);

        // Write with wready early and awready late, then read the word back
        push_req(8'h0F, 32'h40, 64'h1122_3344_5566_7788, 2'b00);
        run(SKEW, 50);
        push_req(8'h00, 32'h40, '0, 2'b00);
        run(FAST, 50);
        check("skew_merge", rdata_o, 64'h0000_0040_5566_7788);

        // Error responses on a read and on a write
        push_req(8'h00, 32'h80, '0, 2'b10);
        push_req(8'hF0, 32'h88, 64'hA5A5_5A5A_0F0F_F0F0, 2'b11);
        run(FAST, 50);

        // Three reads with req_i held high throughout
        g0 = n_gnt; c0 = n_cpl;
        push_req(8'h00, 32'h100, '0, 2'b00);
        push_req(8'h00, 32'h108, '0, 2'b00);
        push_req(8'h00, 32'h110, '0, 2'b00);
        run(FAST, 50);
        check("b2b_grants", 64'(n_gnt - g0), 3);
        check("b2b_completions", 64'(n_cpl - c0), 3);

        // Unaligned byte address is word-aligned on the bus
        push_req(8'h00, 32'h1007, '0, 2'b00);
        run(FAST, 50);
        check("unaligned_araddr", 64'(last_araddr), 64'h1000);

        // Reset while waiting for the write response
        req_i = 1'b1; we_i = 8'hFF; addr_i = 32'h2000; wdata_i = 64'h0102_0304_0506_0708;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1; axi.bvalid = 1'b0;
        axi.rvalid = 1'b0;
        #1;
        check("mid_gnt", 64'(gnt_o), 1);
        @(posedge clk); #1;
        req_i = 1'b0;
        #1;
        check("mid_write_valids", 64'({axi.awvalid, axi.wvalid}), 64'h3);
        @(posedge clk); #2;
        check("mid_wr_resp_bready", 64'(axi.bready), 1);
        check("mid_wr_resp_busy", 64'(busy_o), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        last_rdata = '0;
        axi.bvalid = 1'b1; axi.bresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("late_b_bready", 64'(axi.bready), 0);
            @(posedge clk); #1;
            check("late_b_rvalid", 64'(rvalid_o), 0);
            check("late_b_busy", 64'(busy_o), 0);
        end
        axi.bvalid = 1'b0;

        // Randomized mix of reads and writes over a small word range
        for (int i = 0; i < 60; i++) begin
            push_req(($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                     32'($urandom_range(0, 255)), {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        end
        run(RAND, 3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
